// File: rtl/in_matrix_pkg.sv
// Shared sizing helpers and the per-bank status encoding for the ping-pong input buffer.
package in_matrix_pkg;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;

  function automatic int words(input int n, input int width);
    return n * n / width;
  endfunction

  function automatic int bpw(input int bits, input int width);
    return width * bits / 8;
  endfunction

endpackage

// File: rtl/in_matrix_pingpong_matrix_bank.sv
// One matrix bank: word storage with byte-enable writes, a written-word mask,
// a popcount of that mask and a full flag that latches once every word is written.
module matrix_bank
  import in_matrix_pkg::*;
#(
  parameter int WORDS = 16,
  parameter int WB    = 32,
  localparam int IW   = $clog2(WORDS),
  localparam int CW   = $clog2(WORDS + 1),
  localparam int BEW  = WB / 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr,
  input  logic [IW-1:0]             widx,
  input  logic [WB-1:0]             wdata,
  input  logic [BEW-1:0]            be,
  input  logic                      clr,
  input  logic                      rel,
  output logic [WORDS-1:0][WB-1:0]  data,
  output logic [CW-1:0]             cnt,
  output bank_state_t               state,
  output logic                      done
);

  logic [WORDS-1:0][WB-1:0] data_q, data_d;
  logic [WORDS-1:0]         mask_q, mask_d;
  logic                     full_q, full_d;

  // A full bank ignores writes and clears; only a release empties it.
  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    full_d = full_q;
    if (rel) begin
      mask_d = '0;
      full_d = 1'b0;
    end else if (clr && !full_q) begin
      mask_d = '0;
    end else if (wr && !full_q) begin
      for (int b = 0; b < BEW; b++) begin
        if (be[b]) data_d[widx][8*b +: 8] = wdata[8*b +: 8];
      end
      if (|be) mask_d[widx] = 1'b1;
      if (&mask_d) full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      mask_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      full_q <= full_d;
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < WORDS; i++) cnt = cnt + CW'(mask_q[i]);
  end

  always_comb begin
    if (full_q)       state = FULL;
    else if (|mask_q) state = FILLING;
    else              state = EMPTY;
  end

  assign done = full_d & ~full_q;
  assign data = data_q;

endmodule

// File: rtl/in_matrix_pingpong.sv
// Ping-pong matrix input buffer: bus writes fill one bank while the other bank's
// complete matrix is presented to the core; banks swap on completion and on out_ack.
module in_matrix_pingpong
  import in_matrix_pkg::*;
#(
  parameter int BITS       = 8,
  parameter int N          = 8,
  parameter int WIDTH      = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int OFFSET     = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wr_en,
  input  logic [ADDR_WIDTH-1:0]                addr,
  input  logic [WIDTH*BITS-1:0]                wdata,
  input  logic [WIDTH*BITS/8-1:0]              be,
  input  logic                                 clear,
  output logic                                 wr_ack,
  output logic                                 wr_err,
  output logic [$clog2(words(N, WIDTH)+1)-1:0] fill_cnt,
  output logic                                 out_valid,
  output logic [N*N*BITS-1:0]                  out_all,
  input  logic                                 out_ack
);

  localparam int WORDS = words(N, WIDTH);
  localparam int BPW   = bpw(BITS, WIDTH);
  localparam int WB    = WIDTH * BITS;
  localparam int IW    = $clog2(WORDS);
  localparam int CW    = $clog2(WORDS + 1);

  // One extra bit so a window ending at the top of the address space still compares correctly.
  localparam logic [ADDR_WIDTH:0] WIN_LO = (ADDR_WIDTH+1)'(OFFSET);
  localparam logic [ADDR_WIDTH:0] WIN_HI = (ADDR_WIDTH+1)'(OFFSET + WORDS * BPW);

  logic                  fill_sel_q, fill_sel_d;
  logic                  rd_sel_q, rd_sel_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  wr_err_q, wr_err_d;

  logic                  in_win;
  logic [ADDR_WIDTH-1:0] offs;
  logic [IW-1:0]         widx;
  logic                  fill_full;
  logic                  accept;
  logic                  release_rd;

  logic [1:0]               bank_wr, bank_clr, bank_rel, bank_done, bank_full;
  logic [CW-1:0]            bank_cnt  [2];
  bank_state_t              bank_st   [2];
  logic [WORDS-1:0][WB-1:0] bank_data [2];

  assign in_win     = ({1'b0, addr} >= WIN_LO) && ({1'b0, addr} < WIN_HI);
  assign offs       = addr - ADDR_WIDTH'(OFFSET);
  assign widx       = IW'(offs / ADDR_WIDTH'(BPW));
  assign fill_full  = bank_full[fill_sel_q];
  assign accept     = wr_en & in_win & ~fill_full;
  assign release_rd = out_ack & bank_full[rd_sel_q];

  for (genvar i = 0; i < 2; i++) begin : g_bank
    assign bank_wr[i]   = accept & ~clear & (int'(fill_sel_q) == i);
    assign bank_clr[i]  = clear & (int'(fill_sel_q) == i);
    assign bank_rel[i]  = release_rd & (int'(rd_sel_q) == i);
    assign bank_full[i] = (bank_st[i] == FULL);

    matrix_bank #(
      .WORDS (WORDS),
      .WB    (WB)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .wr    (bank_wr[i]),
      .widx  (widx),
      .wdata (wdata),
      .be    (be),
      .clr   (bank_clr[i]),
      .rel   (bank_rel[i]),
      .data  (bank_data[i]),
      .cnt   (bank_cnt[i]),
      .state (bank_st[i]),
      .done  (bank_done[i])
    );
  end

  // Completion on the fill bank and release of the read bank can land on the same edge.
  always_comb begin
    fill_sel_d = fill_sel_q ^ (|bank_done);
    rd_sel_d   = rd_sel_q ^ release_rd;
    wr_ack_d   = accept;
    wr_err_d   = wr_en & in_win & fill_full;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_sel_q <= 1'b0;
      rd_sel_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      fill_sel_q <= fill_sel_d;
      rd_sel_q   <= rd_sel_d;
      wr_ack_q   <= wr_ack_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign wr_ack    = wr_ack_q;
  assign wr_err    = wr_err_q;
  assign fill_cnt  = bank_cnt[fill_sel_q];
  assign out_valid = bank_full[rd_sel_q];
  assign out_all   = bank_data[rd_sel_q];

endmodule

// File: tb/tb_in_matrix_pingpong.sv
// Scoreboard bench for in_matrix_pingpong (16 words of 32 bits, window at 0x40).
module tb_in_matrix_pingpong;

  logic         clk;
  logic         rst;
  logic         wr_en;
  logic [9:0]   addr;
  logic [31:0]  wdata;
  logic [3:0]   be;
  logic         clear;
  logic         wr_ack;
  logic         wr_err;
  logic [4:0]   fill_cnt;
  logic         out_valid;
  logic [511:0] out_all;
  logic         out_ack;

  in_matrix_pingpong #(
    .BITS(8), .N(8), .WIDTH(4), .ADDR_WIDTH(10), .OFFSET(64)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .addr(addr), .wdata(wdata), .be(be),
    .clear(clear), .wr_ack(wr_ack), .wr_err(wr_err), .fill_cnt(fill_cnt),
    .out_valid(out_valid), .out_all(out_all), .out_ack(out_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct { int cyc; bit ack; bit err; } resp_t;
  resp_t exp_q[$];

  // Reference model: two banks of 16 words, which words were written, full flags, pointers.
  logic [31:0] m_data [2][16];
  bit          m_wr   [2][16];
  bit          m_full [2];
  int          m_fill;
  int          m_rd;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_full[b] = 0;
      for (int i = 0; i < 16; i++) begin
        m_data[b][i] = '0;
        m_wr[b][i]   = 0;
      end
    end
    m_fill = 0;
    m_rd   = 0;
  endtask

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(m_wr[m_fill][i]);
    return c;
  endfunction

  function automatic logic [511:0] model_all();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[32*k +: 32] = m_data[m_rd][k];
    return v;
  endfunction

  task automatic model_step(input bit w, input logic [9:0] a, input logic [31:0] d,
                            input logic [3:0] b, input bit c, input bit k,
                            output bit ack, output bit err);
    bit win, fill_full, rel, all;
    int wi;
    win       = (a >= 10'h40) && (a < 10'h80);
    wi        = int'((a - 10'h40) >> 2);
    fill_full = m_full[m_fill];
    rel       = k && m_full[m_rd];
    ack       = w && win && !fill_full;
    err       = w && win && fill_full;
    if (c && !fill_full) begin
      for (int i = 0; i < 16; i++) m_wr[m_fill][i] = 0;
    end else if (ack) begin
      for (int j = 0; j < 4; j++)
        if (b[j]) m_data[m_fill][wi][8*j +: 8] = d[8*j +: 8];
      if (b != 4'h0) m_wr[m_fill][wi] = 1;
      all = 1;
      for (int i = 0; i < 16; i++) all = all && m_wr[m_fill][i];
      if (all) begin
        m_full[m_fill] = 1;
        m_fill ^= 1;
      end
    end
    if (rel) begin
      m_full[m_rd] = 0;
      for (int i = 0; i < 16; i++) m_wr[m_rd][i] = 0;
      m_rd ^= 1;
    end
  endtask

  // Called at a negedge: applies one cycle of stimulus, checks state at the next negedge.
  task automatic drive(input bit w, input logic [9:0] a, input logic [31:0] d,
                       input logic [3:0] b, input bit c, input bit k);
    resp_t r;
    wr_en = w; addr = a; wdata = d; be = b; clear = c; out_ack = k;
    model_step(w, a, d, b, c, k, r.ack, r.err);
    r.cyc = cyc + 1;
    exp_q.push_back(r);
    @(negedge clk);
    chk("out_valid", 512'(out_valid), 512'(m_full[m_rd]));
    chk("fill_cnt", 512'(fill_cnt), 512'(model_cnt()));
    chk("out_all", out_all, model_all());
  endtask

  task automatic idle();
    drive(0, 10'h0, 32'h0, 4'h0, 0, 0);
  endtask

  task automatic wr_word(input int wi, input logic [31:0] d, input logic [3:0] b);
    drive(1, 10'(10'h40 + 4 * wi), d, b, 0, 0);
  endtask

  task automatic fill_range(input int lo, input int hi, input int skip);
    for (int i = lo; i <= hi; i++)
      if (i != skip) wr_word(i, $urandom, 4'hF);
  endtask

  task automatic drain();
    for (int i = 0; i < 2; i++)
      if (m_full[m_rd]) drive(0, 10'h0, 32'h0, 4'h0, 0, 1);
  endtask

  task automatic do_reset();
    wr_en = 0; clear = 0; out_ack = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_out_all", out_all, 512'(0));
    chk("rst_fill_cnt", 512'(fill_cnt), 512'(0));
    chk("rst_wr_ack", 512'(wr_ack), 512'(0));
    chk("rst_wr_err", 512'(wr_err), 512'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        resp_t e;
        e = exp_q.pop_front();
        chk("wr_ack", 512'(wr_ack), 512'(e.ack));
        chk("wr_err", 512'(wr_err), 512'(e.err));
      end else if (wr_ack || wr_err) begin
        chk("unexpected_resp", 512'({wr_ack, wr_err}), 512'(0));
      end
    end
  end

  logic [31:0] w0, old5, new5;

  initial begin
    rst = 1'b1; wr_en = 0; addr = '0; wdata = '0; be = '0; clear = 0; out_ack = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_out_valid", 512'(out_valid), 512'(0));
    chk("init_out_all", out_all, 512'(0));
    chk("init_fill_cnt", 512'(fill_cnt), 512'(0));
    rst = 1'b0;

    // 1: full bank fill, matrix appears after the 16th write
    w0 = $urandom;
    wr_word(0, w0, 4'hF);
    fill_range(1, 15, -1);
    chk("t1_valid", 512'(out_valid), 512'(1));
    chk("t1_word0", 512'(out_all[31:0]), 512'(w0));

    // 2: both banks full -> error, then hand over to bank1
    fill_range(0, 15, -1);
    wr_word(3, 32'hDEADBEEF, 4'hF);
    drive(0, 10'h0, 32'h0, 4'h0, 0, 1);
    chk("t2_valid_after_ack", 512'(out_valid), 512'(1));
    drain();

    // 3: rewrite with partial byte enables, count stays 1
    old5 = 32'hA1B2C3D4;
    new5 = 32'h11223344;
    wr_word(5, old5, 4'hF);
    wr_word(5, new5, 4'h3);
    chk("t3_fill_cnt", 512'(fill_cnt), 512'(1));
    fill_range(0, 15, 5);
    chk("t3_word5", 512'(out_all[5*32 +: 32]), 512'({old5[31:16], new5[15:0]}));
    drain();

    // 4: out-of-window writes, be=0, clear and write-during-clear
    drive(1, 10'h03C, 32'h1, 4'hF, 0, 0);
    drive(1, 10'h080, 32'h2, 4'hF, 0, 0);
    chk("t4_cnt_oow", 512'(fill_cnt), 512'(0));
    wr_word(2, 32'h5, 4'h0);
    fill_range(0, 14, -1);
    drive(1, 10'h07C, 32'h7, 4'hF, 1, 0);
    chk("t4_cnt_clear", 512'(fill_cnt), 512'(0));
    fill_range(0, 15, -1);
    chk("t4_refill_valid", 512'(out_valid), 512'(1));
    drain();

    // 5: reset mid-fill and with a visible matrix
    fill_range(0, 7, -1);
    do_reset();
    fill_range(0, 15, -1);
    do_reset();
    fill_range(0, 15, -1);
    chk("t5_fresh_valid", 512'(out_valid), 512'(1));

    // 6: completion of bank1 and release of bank0 on the same edge
    fill_range(0, 14, -1);
    drive(1, 10'h07C, $urandom, 4'hF, 0, 1);
    chk("t6_valid_kept", 512'(out_valid), 512'(1));
    wr_word(9, $urandom, 4'hF);
    chk("t6_next_fill_cnt", 512'(fill_cnt), 512'(1));
    drain();

    // 7: randomized traffic, including unaligned addresses and window edges
    for (int n = 0; n < 600; n++) begin
      bit w, c, k;
      logic [9:0] a;
      w = ($urandom_range(0, 3) != 0);
      a = 10'(10'h38 + $urandom_range(0, 'h4C));
      c = ($urandom_range(0, 39) == 0);
      k = ($urandom_range(0, 5) == 0);
      drive(w, a, $urandom, 4'($urandom_range(0, 15)), c, k);
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
